// File: rtl/alu_board_pkg.sv
// Shared definitions for the ALU result-buffer slice: FSM state encoding and size defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_board_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/res_ram.sv
// Result storage: one write port, one registered read port, whole array cleared by reset.
// Latency: read data appears one cycle after re; write visible to reads on the following cycle.
// Backpressure: none; rdata holds its value whenever re is low.
//
// Ports: clk, reset (async active-low), we/waddr/wdata (write port),
//        re/raddr (read request), rdata (registered read data).
module res_ram #(
    parameter int EW    = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [EW-1:0]            wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [EW-1:0]            rdata
);

    logic [EW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (re) begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/res_writer.sv
// ALU result writer: stores {C4,F} by auto pointer or direct address, and dumps all stored entries.
// Latency: entry k is on data/cout (valid=1) k+1 cycles after dump is sampled; done follows the last entry.
// Backpressure: none; stores beyond DEPTH are dropped and flagged on sticky ovf.
//
// Ports: clk, reset (async active-low); F, C4, v[3] (store strobe), A/adr (direct write select/address),
//        dump, clear (IDLE only); data, cout, valid (readback); busy, full, ovf, done (status).
// Build option: define CARRY_STORE_EN to keep C4 per entry and return it on cout; otherwise cout=0.
module res_writer
    import alu_board_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         F,
    input  logic                     C4,
    input  logic [3:0]               v,
    input  logic                     A,
    input  logic [$clog2(DEPTH)-1:0] adr,
    input  logic                     dump,
    input  logic                     clear,
    output logic [WIDTH-1:0]         data,
    output logic                     cout,
    output logic                     valid,
    output logic                     busy,
    output logic                     full,
    output logic                     ovf,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef CARRY_STORE_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    state_t         state, state_nxt;
    logic [AW-1:0]  wptr, rptr, waddr;
    logic [CW-1:0]  count;
    logic [EW-1:0]  wdata, rdata;
    logic           we, re, do_push, do_ovf, do_clear, start, last;

`ifdef CARRY_STORE_EN
    logic [2:0] unused_strobes;
    assign unused_strobes = v[2:0];
    assign wdata          = {C4, F};
    assign cout           = rdata[WIDTH];
`else
    logic [3:0] unused_inputs;
    assign unused_inputs = {v[2:0], C4};
    assign wdata         = F;
    assign cout          = 1'b0;
`endif

    assign data = rdata[WIDTH-1:0];
    assign full = (count == CW'(DEPTH));
    assign busy = (state == DUMP);
    // Last entry is the one at index count-1; rptr is widened to compare against count.
    assign last = ({1'b0, rptr} == (count - CW'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        waddr     = wptr;
        re        = 1'b0;
        do_push   = 1'b0;
        do_ovf    = 1'b0;
        do_clear  = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (clear) begin
                    do_clear = 1'b1;
                end else if (v[3]) begin
                    // A store always beats a simultaneous dump request.
                    if (A) begin
                        we    = 1'b1;
                        waddr = adr;
                    end else if (!full) begin
                        we      = 1'b1;
                        do_push = 1'b1;
                    end else begin
                        do_ovf = 1'b1;
                    end
                end else if (dump) begin
                    start     = 1'b1;
                    state_nxt = (count == '0) ? DONE : DUMP;
                end
            end
            DUMP: begin
                re = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            valid <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (do_clear) begin
                wptr  <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end else if (do_push) begin
                wptr  <= wptr + AW'(1);
                count <= count + CW'(1);
            end else if (do_ovf) begin
                ovf <= 1'b1;
            end
            if (start) begin
                rptr <= '0;
            end else if (re) begin
                rptr <= rptr + AW'(1);
            end
            valid <= re;
            // done is a registered copy of DONE so it lands in the cycle after the last valid entry.
            done  <= (state == DONE);
        end
    end

    res_ram #(
        .EW    (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (rptr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_res_writer.sv
module tb_res_writer;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] F = '0;
    logic             C4 = 1'b0;
    logic [3:0]       v = '0;
    logic             A = 1'b0;
    logic [AW-1:0]    adr = '0;
    logic             dump = 1'b0;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] data;
    logic             cout, valid, busy, full, ovf, done;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: buffer contents, number of auto-stored entries, sticky overflow.
    logic [WIDTH-1:0] m_dat [DEPTH];
    logic             m_car [DEPTH];
    int               m_count = 0;
    bit               m_ovf = 0;

    res_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .F(F), .C4(C4), .v(v), .A(A), .adr(adr),
        .dump(dump), .clear(clear), .data(data), .cout(cout), .valid(valid),
        .busy(busy), .full(full), .ovf(ovf), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_dat[i] = '0;
            m_car[i] = 1'b0;
        end
        m_count = 0;
        m_ovf   = 0;
    endtask

    task automatic do_store(input logic [WIDTH-1:0] f, input logic c, input logic a, input logic [AW-1:0] ad);
        @(negedge clk);
        F = f; C4 = c; A = a; adr = ad; v = 4'b1000;
        @(negedge clk);
        v = 4'b0000;
        if (a) begin
            m_dat[ad] = f; m_car[ad] = c;
        end else if (m_count < DEPTH) begin
            m_dat[m_count % DEPTH] = f; m_car[m_count % DEPTH] = c;
            m_count++;
        end else begin
            m_ovf = 1;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_count = 0;
        m_ovf   = 0;
    endtask

    // Issues one dump and checks every cycle of the readback against the model.
    task automatic test_dump(input string tag);
        bit               ev, eb, edn, ec;
        logic [WIDTH-1:0] ed;
        int               idx;
        @(negedge clk);
        dump = 1'b1;
        for (int c = 0; c < DEPTH + 3; c++) begin
            @(negedge clk);
            dump = 1'b0;
            ev  = (c >= 1) && (c <= m_count);
            eb  = (c < m_count);
            edn = (c == m_count + 1);
            n_chk++;
            if (valid !== ev) $display("FAIL %s valid c=%0d got %b want %b", tag, c, valid, ev);
            else n_pass++;
            n_chk++;
            if (busy !== eb) $display("FAIL %s busy c=%0d got %b want %b", tag, c, busy, eb);
            else n_pass++;
            n_chk++;
            if (done !== edn) $display("FAIL %s done c=%0d got %b want %b", tag, c, done, edn);
            else n_pass++;
            if (m_count > 0 && c >= 1) begin
                idx = (c <= m_count) ? c - 1 : m_count - 1;
                ed  = m_dat[idx];
`ifdef CARRY_STORE_EN
                ec = m_car[idx];
`else
                ec = 1'b0;
`endif
                n_chk++;
                if (data !== ed) $display("FAIL %s data c=%0d got %h want %h", tag, c, data, ed);
                else n_pass++;
                n_chk++;
                if (cout !== ec) $display("FAIL %s cout c=%0d got %b want %b", tag, c, cout, ec);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if ({data, cout, valid, busy, full, ovf, done} !== '0)
            $display("FAIL reset_outputs got %b want 0", {data, cout, valid, busy, full, ovf, done});
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({valid, busy, full, ovf, done} !== 5'b0)
            $display("FAIL post_reset_flags got %b want 00000", {valid, busy, full, ovf, done});
        else n_pass++;
        test_dump("empty_dump");
    endtask

    task automatic test_basic();
        do_clear();
        do_store(4'h3, 1'($urandom_range(0, 1)), 1'b0, '0);
        do_store(4'h5, 1'($urandom_range(0, 1)), 1'b0, '0);
        do_store(4'h9, 1'($urandom_range(0, 1)), 1'b0, '0);
        test_dump("basic_359");
    endtask

    task automatic test_full_ovf();
        do_clear();
        for (int i = 0; i < DEPTH; i++) do_store(4'($urandom), 1'($urandom), 1'b0, '0);
        n_chk++;
        if (full !== 1'b1 || ovf !== 1'b0) $display("FAIL full_at_8 full=%b ovf=%b want full=1 ovf=0", full, ovf);
        else n_pass++;
        do_store(~m_dat[0], ~m_car[0], 1'b0, '0);
        n_chk++;
        if (full !== 1'b1 || ovf !== 1'b1) $display("FAIL ovf_on_9th full=%b ovf=%b want full=1 ovf=1", full, ovf);
        else n_pass++;
        test_dump("full_dump");
        n_chk++;
        if (ovf !== 1'b1) $display("FAIL ovf_sticky got %b want 1", ovf);
        else n_pass++;
        do_clear();
        n_chk++;
        if (full !== 1'b0 || ovf !== 1'b0) $display("FAIL clear_flags full=%b ovf=%b want 0 0", full, ovf);
        else n_pass++;
    endtask

    task automatic test_direct();
        do_clear();
        for (int i = 0; i < 6; i++) do_store(4'($urandom), 1'($urandom), 1'b0, '0);
        do_store(4'hA, 1'b1, 1'b1, 3'd5);
        do_store(4'($urandom), 1'b0, 1'b1, 3'd7);
        n_chk++;
        if (full !== 1'b0) $display("FAIL direct_not_full got %b want 0", full);
        else n_pass++;
        test_dump("direct_adr5");
    endtask

    task automatic test_store_dump_same();
        logic [WIDTH-1:0] f;
        do_clear();
        do_store(4'($urandom), 1'($urandom), 1'b0, '0);
        do_store(4'($urandom), 1'($urandom), 1'b0, '0);
        f = 4'($urandom);
        @(negedge clk);
        F = f; C4 = 1'b1; A = 1'b0; v = 4'b1000; dump = 1'b1;
        @(negedge clk);
        v = 4'b0000; dump = 1'b0;
        m_dat[m_count] = f; m_car[m_count] = 1'b1; m_count++;
        for (int c = 0; c < 2; c++) begin
            n_chk++;
            if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL same_cycle c=%0d busy=%b valid=%b want 0 0", c, busy, valid);
            else n_pass++;
            @(negedge clk);
        end
        test_dump("after_same_cycle");
    endtask

    task automatic test_reset_mid_dump();
        do_clear();
        for (int i = 0; i < 4; i++) do_store(4'($urandom), 1'($urandom), 1'b0, '0);
        @(negedge clk);
        dump = 1'b1;
        @(negedge clk);
        dump = 1'b0;
        n_chk++;
        if (busy !== 1'b1) $display("FAIL mid_dump_busy1 got %b want 1", busy);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b1 || valid !== 1'b1) $display("FAIL mid_dump_busy2 busy=%b valid=%b want 1 1", busy, valid);
        else n_pass++;
        reset = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_flags valid=%b busy=%b done=%b want 0 0 0", valid, busy, done);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++;
            if (done !== 1'b0 || valid !== 1'b0) $display("FAIL abort_no_done c=%0d done=%b valid=%b", c, done, valid);
            else n_pass++;
        end
        test_dump("after_abort");
    endtask

    task automatic test_carry();
        do_clear();
        do_store(4'hF, 1'b1, 1'b0, '0);
        test_dump("carry_store");
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 5; it++) begin
            do_clear();
            n = $urandom_range(1, DEPTH + 2);
            for (int i = 0; i < n; i++)
                do_store(4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 3'($urandom));
            n_chk++;
            if (full !== (m_count == DEPTH) || ovf !== m_ovf)
                $display("FAIL rand_flags it=%0d full=%b ovf=%b want %b %b", it, full, ovf, m_count == DEPTH, m_ovf);
            else n_pass++;
            test_dump("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_ovf();
        test_direct();
        test_store_dump_same();
        test_reset_mid_dump();
        test_carry();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
